// File: rtl/uart_boot_loader.sv
// uart_boot_loader: drives the UART register bus as initiator, drains received bytes,
// parses an 0xA5-framed image (little-endian 32-bit length + payload) and writes it
// word by word into instruction memory, holding the CPU in reset until the load is done.
// Optional feature: define UART_BOOT_LOADER_ACK_EN to send ACK_BYTE back over the UART
// transmit buffer before done is raised.
module uart_boot_loader #(
  parameter logic [31:0] MEM_BASE = 32'h0000_0000,
  parameter int unsigned MAX_LEN  = 4096,
  parameter logic [7:0]  ACK_BYTE = 8'h06
) (
  input  logic        clk,
  input  logic        reset,
  output logic [5:0]  u_addr,
  input  logic [31:0] u_rdata,
  output logic [31:0] u_wdata,
  output logic        u_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        cpu_reset,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    StPoll, StChk, StFetch, StTake, StIdle
  } bus_state_e;

  typedef enum logic [2:0] {
    StSync, StLen0, StLen1, StLen2, StLen3, StData, StFin
  } frame_state_e;

  bus_state_e   bus_q, bus_d;
  frame_state_e frame_q, frame_d;

  logic [3:0]  rd_ptr_q, rd_ptr_d;
  logic [31:0] len_q, len_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] word_q, word_d;
  logic [31:0] waddr_q, waddr_d;

  logic [5:0]  u_addr_q, u_addr_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_we_q, mem_we_d;
  logic        cpu_reset_q, cpu_reset_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

`ifdef UART_BOOT_LOADER_ACK_EN
  logic [3:0]  wp_q, wp_d;
  logic [1:0]  ack_step_q, ack_step_d;
  logic        u_we_q, u_we_d;
  logic [31:0] u_wdata_q, u_wdata_d;
`endif

  logic        take;
  logic [7:0]  rx_byte;
  logic [31:0] len_full;
  logic [31:0] packed_word;

  // Byte selection from the fetched receive word, and the length/word being assembled.
  always_comb begin
    rx_byte     = u_rdata[{rd_ptr_q[1:0], 3'b000} +: 8];
    len_full    = {rx_byte, len_q[23:0]};
    packed_word = word_q;
    packed_word[{lane_q, 3'b000} +: 8] = rx_byte;
  end

  // Next-state logic for the bus FSM, frame FSM and all registered outputs.
  always_comb begin
    bus_d       = bus_q;
    frame_d     = frame_q;
    rd_ptr_d    = rd_ptr_q;
    len_d       = len_q;
    lane_d      = lane_q;
    word_d      = word_q;
    waddr_d     = waddr_q;
    u_addr_d    = u_addr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    err_d       = 1'b0;
    take        = 1'b0;
`ifdef UART_BOOT_LOADER_ACK_EN
    wp_d        = wp_q;
    ack_step_d  = ack_step_q;
    u_we_d      = 1'b0;
    u_wdata_d   = u_wdata_q;
`endif

    unique case (bus_q)
      StPoll: bus_d = StChk;
      StChk: begin
        // u_addr has pointed at status since entering POLL; compare write pointer.
        if (u_rdata[11:8] != rd_ptr_q) begin
          bus_d    = StFetch;
          u_addr_d = {2'b01, rd_ptr_q[3:2], 2'b00};
        end else begin
          bus_d = StPoll;
        end
      end
      StFetch: bus_d = StTake;
      StTake: begin
        take     = 1'b1;
        rd_ptr_d = rd_ptr_q + 4'd1;
        u_addr_d = 6'h00;
        bus_d    = StPoll;
      end
      StIdle: bus_d = StIdle;
      default: bus_d = StPoll;
    endcase

    if (take) begin
      unique case (frame_q)
        StSync: if (rx_byte == 8'hA5) frame_d = StLen0;
        StLen0: begin
          len_d[7:0] = rx_byte;
          frame_d    = StLen1;
        end
        StLen1: begin
          len_d[15:8] = rx_byte;
          frame_d     = StLen2;
        end
        StLen2: begin
          len_d[23:16] = rx_byte;
          frame_d      = StLen3;
        end
        StLen3: begin
          if (len_full > MAX_LEN) begin
            err_d   = 1'b1;
            frame_d = StSync;
          end else if (len_full == 32'd0) begin
            frame_d = StFin;
          end else begin
            len_d   = len_full;
            lane_d  = 2'd0;
            word_d  = 32'd0;
            frame_d = StData;
          end
        end
        StData: begin
          word_d = packed_word;
          len_d  = len_q - 32'd1;
          lane_d = lane_q + 2'd1;
          // Flush on a full word or on the last image byte; clearing keeps unused lanes zero.
          if (lane_q == 2'd3 || len_q == 32'd1) begin
            mem_we_d    = 1'b1;
            mem_wdata_d = packed_word;
            mem_addr_d  = waddr_q;
            waddr_d     = waddr_q + 32'd4;
            word_d      = 32'd0;
            lane_d      = 2'd0;
          end
          if (len_q == 32'd1) frame_d = StFin;
        end
        default: frame_d = frame_q;
      endcase
    end

    // Once the image is complete no further bus reads are issued.
    if (frame_d == StFin) begin
      bus_d = StIdle;
    end

    if (frame_q == StFin) begin
`ifdef UART_BOOT_LOADER_ACK_EN
      unique case (ack_step_q)
        2'd0: begin
          u_we_d     = 1'b1;
          u_addr_d   = {2'b10, wp_q[3:2], 2'b00};
          u_wdata_d  = 32'd0;
          u_wdata_d[{wp_q[1:0], 3'b000} +: 8] = ACK_BYTE;
          ack_step_d = 2'd1;
        end
        2'd1: begin
          u_we_d     = 1'b1;
          u_addr_d   = 6'h00;
          u_wdata_d  = {28'd0, wp_q + 4'd1};
          wp_d       = wp_q + 4'd1;
          ack_step_d = 2'd2;
        end
        2'd2: begin
          u_wdata_d   = 32'd0;
          done_d      = 1'b1;
          cpu_reset_d = 1'b0;
          ack_step_d  = 2'd3;
        end
        default: ack_step_d = 2'd3;
      endcase
`else
      done_d      = 1'b1;
      cpu_reset_d = 1'b0;
`endif
    end
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_q       <= StPoll;
      frame_q     <= StSync;
      rd_ptr_q    <= 4'd0;
      len_q       <= 32'd0;
      lane_q      <= 2'd0;
      word_q      <= 32'd0;
      waddr_q     <= MEM_BASE;
      u_addr_q    <= 6'h00;
      mem_addr_q  <= MEM_BASE;
      mem_wdata_q <= 32'd0;
      mem_we_q    <= 1'b0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef UART_BOOT_LOADER_ACK_EN
      wp_q        <= 4'd0;
      ack_step_q  <= 2'd0;
      u_we_q      <= 1'b0;
      u_wdata_q   <= 32'd0;
`endif
    end else begin
      bus_q       <= bus_d;
      frame_q     <= frame_d;
      rd_ptr_q    <= rd_ptr_d;
      len_q       <= len_d;
      lane_q      <= lane_d;
      word_q      <= word_d;
      waddr_q     <= waddr_d;
      u_addr_q    <= u_addr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef UART_BOOT_LOADER_ACK_EN
      wp_q        <= wp_d;
      ack_step_q  <= ack_step_d;
      u_we_q      <= u_we_d;
      u_wdata_q   <= u_wdata_d;
`endif
    end
  end

  assign u_addr    = u_addr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign cpu_reset = cpu_reset_q;
  assign done      = done_q;
  assign err       = err_q;

`ifdef UART_BOOT_LOADER_ACK_EN
  assign u_we    = u_we_q;
  assign u_wdata = u_wdata_q;
`else
  // No transmit path: the write port is constant zero (ACK_BYTE masked to zero).
  assign u_we    = 1'b0;
  assign u_wdata = {24'd0, ACK_BYTE & 8'h00};
`endif

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: a UART receive-ring model feeds framed images,
// a frame-level reference model predicts memory/ACK writes, and a monitor checks them.
module tb_uart_boot_loader;

  localparam logic [31:0] MemBase = 32'h0000_0100;
  localparam int unsigned MaxLen  = 4096;
`ifdef UART_BOOT_LOADER_ACK_EN
  localparam int DoneLag = 3;
`else
  localparam int DoneLag = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  u_addr;
  logic [31:0] u_rdata;
  logic [31:0] u_wdata;
  logic        u_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        cpu_reset;
  logic        done;
  logic        err;

  uart_boot_loader #(
    .MEM_BASE(MemBase),
    .MAX_LEN (MaxLen),
    .ACK_BYTE(8'h06)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .u_addr   (u_addr),
    .u_rdata  (u_rdata),
    .u_wdata  (u_wdata),
    .u_we     (u_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .cpu_reset(cpu_reset),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         exp_u_q[$];
  logic [7:0]  stim_q[$];
  int          exp_err_n = 0;
  logic        exp_done = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;

  // UART receive ring model.
  logic [7:0]  rx_mem [16];
  logic [3:0]  rx_wp = 4'd0;

  always_comb begin
    u_rdata = 32'd0;
    if (u_addr == 6'h00) begin
      u_rdata = {20'd0, rx_wp, 8'd0};
    end else if (u_addr[5:4] == 2'b01) begin
      u_rdata = {rx_mem[{u_addr[3:2], 2'b11}], rx_mem[{u_addr[3:2], 2'b10}],
                 rx_mem[{u_addr[3:2], 2'b01}], rx_mem[{u_addr[3:2], 2'b00}]};
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write or a status change.
  int   last_we_cyc = 0;
  logic wrote = 1'b0;
  logic done_prev = 1'b0;
  logic err_prev = 1'b0;
  always @(negedge clk) begin
    wr_t e;
    if (reset) begin
      wrote     = 1'b0;
      done_prev = 1'b0;
      err_prev  = 1'b0;
    end else begin
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          check("mem_we_unexpected", {31'd0, mem_we}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("mem_addr", mem_addr, e.addr);
          check("mem_wdata", mem_wdata, e.data);
        end
        last_we_cyc = cyc;
        wrote       = 1'b1;
      end
      if (u_we) begin
        if (exp_u_q.size() == 0) begin
          check("u_we_unexpected", {31'd0, u_we}, 32'd0);
        end else begin
          e = exp_u_q.pop_front();
          check("u_addr", {26'd0, u_addr}, e.addr);
          check("u_wdata", u_wdata, e.data);
        end
      end
      if (err) begin
        check("err_expected", {31'd0, exp_err_n > 0}, 32'd1);
        if (exp_err_n > 0) exp_err_n--;
        if (err_prev) check("err_one_cycle", {31'd0, err_prev}, 32'd0);
      end
      if (done && !done_prev) begin
        check("cpu_reset_with_done", {31'd0, cpu_reset}, 32'd0);
        if (wrote) check("done_lag", cyc - last_we_cyc, DoneLag);
      end
      done_prev = done;
      err_prev  = err;
    end
  end

  // Reference model: scans the byte stream at frame level and predicts the writes.
  task automatic model_run();
    int          i = 0;
    int          sz = stim_q.size();
    logic [31:0] len;
    logic [31:0] word;
    while (i < sz) begin
      if (stim_q[i] != 8'hA5) begin
        i++;
        continue;
      end
      if (i + 4 >= sz) break;
      len = {stim_q[i+4], stim_q[i+3], stim_q[i+2], stim_q[i+1]};
      i += 5;
      if (len > MaxLen) begin
        exp_err_n++;
        continue;
      end
      for (int w = 0; w < (int'(len) + 3) / 4; w++) begin
        int last = (4 * w + 4 < int'(len)) ? 4 * w + 4 : int'(len);
        if (i + last > sz) break;
        word = 32'd0;
        for (int k = 0; k < 4; k++) begin
          if (4 * w + k < int'(len)) word[8*k +: 8] = stim_q[i + 4*w + k];
        end
        exp_q.push_back('{addr: MemBase + 32'(4 * w), data: word});
      end
      if (i + int'(len) <= sz) begin
        exp_done = 1'b1;
`ifdef UART_BOOT_LOADER_ACK_EN
        exp_u_q.push_back('{addr: 32'h20, data: 32'h0000_0006});
        exp_u_q.push_back('{addr: 32'h00, data: 32'h0000_0001});
`endif
      end
      break;
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    repeat ($urandom_range(9, 5)) @(posedge clk);
    #1;
    rx_mem[rx_wp] = b;
    rx_wp = rx_wp + 4'd1;
  endtask

  task automatic run_stream();
    model_run();
    foreach (stim_q[j]) push_byte(stim_q[j]);
  endtask

  task automatic add_frame(input int len, input logic [31:0] hdr_len);
    stim_q.push_back(8'hA5);
    for (int k = 0; k < 4; k++) stim_q.push_back(hdr_len[8*k +: 8]);
    for (int k = 0; k < len; k++) stim_q.push_back(8'($urandom_range(255, 0)));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    rx_wp = 4'd0;
    exp_done = 1'b0;
    stim_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("rst_u_addr", {26'd0, u_addr}, 32'd0);
    check("rst_u_wdata_we", {u_wdata[30:0], u_we}, 32'd0);
    check("rst_mem_addr", mem_addr, MemBase);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_flags", {28'd0, mem_we, cpu_reset, done, err}, 32'h4);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic finish_scenario(input string name);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check({name, "_drain"}, exp_q.size(), 0);
    check({name, "_ack_drain"}, exp_u_q.size(), 0);
    check({name, "_err_seen"}, exp_err_n, 0);
    check({name, "_done"}, {31'd0, done}, {31'd0, exp_done});
    check({name, "_cpu_reset"}, {31'd0, cpu_reset}, {31'd0, ~exp_done});
  endtask

  initial begin
    foreach (rx_mem[k]) rx_mem[k] = 8'd0;

    // Directed two-word image.
    do_reset();
    stim_q = '{8'hA5, 8'h08, 8'h00, 8'h00, 8'h00,
               8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_stream();
    finish_scenario("two_words");

    // Leading garbage, partial trailing word.
    do_reset();
    stim_q = '{8'h00, 8'hFF, 8'hA5, 8'h03, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC};
    run_stream();
    finish_scenario("garbage");

    // Over-length rejected, then a valid frame.
    do_reset();
    add_frame(0, 32'h0000_1001);
    add_frame(4, 32'd4);
    run_stream();
    finish_scenario("too_long");

    // Zero-length image.
    do_reset();
    add_frame(0, 32'd0);
    run_stream();
    finish_scenario("zero_len");

    // 20-byte image, receive pointer wraps.
    do_reset();
    add_frame(20, 32'd20);
    run_stream();
    finish_scenario("wrap");

    // Reset in the middle of a load.
    do_reset();
    add_frame(2, 32'd4);
    run_stream();
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("midload_no_done", {31'd0, done}, 32'd0);
    do_reset();
    add_frame(4, 32'd4);
    run_stream();
    finish_scenario("after_reset");

    // Randomized frames with random garbage and trailing bytes.
    for (int r = 0; r < 5; r++) begin
      int len = $urandom_range(24, 1);
      do_reset();
      repeat ($urandom_range(3, 0)) begin
        logic [7:0] g = 8'($urandom_range(255, 0));
        stim_q.push_back(g == 8'hA5 ? 8'h5A : g);
      end
      add_frame(len, 32'(len));
      repeat ($urandom_range(3, 0)) stim_q.push_back(8'($urandom_range(255, 0)));
      run_stream();
      finish_scenario("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
